uio_arbiter: RTL and testbench

Shares the 8-bit bidirectional `uio` pad bank of the FPGA top between two internal requesters, for example the JTAG debug path and a user function. It sits between the `SB_IO` pad instances and the user logic. It grants the bus round-robin and enforces a hold limit so neither requester can lock the bus out. Every ownership change passes through a turnaround window with all output enables low, so two drivers never fight on a pad.

---
 rtl/uio_arb_pkg.sv | 20 ++
 rtl/uio_arb_hold_timer.sv | 52 +++++
 rtl/uio_arbiter.sv | 125 ++++++++++++
 tb/tb_uio_arbiter.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uio_arb_pkg.sv
// uio_arb_pkg: shared types for the uio pad-bank arbiter.
// Provides the FSM state enum, owner encoding and the pad width.
package uio_arb_pkg;

   localparam int UIO_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_OWN_A,
      ST_OWN_B,
      ST_TURN
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE,
      OWN_A,
      OWN_B
   } owner_t;

endpackage

// File: rtl/uio_arb_hold_timer.sv
// uio_arb_hold_timer: saturating grant-hold counter and turnaround timer.
// Ports: clear/hold_en drive the hold count, hold_max flags the limit;
//        start loads the turnaround, turn_en counts it, expired ends it.
module uio_arb_hold_timer
   import uio_arb_pkg::*;
#(
   parameter int MAX_HOLD          = 16,
   parameter int TURNAROUND_CYCLES = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic hold_en,
   input  logic start,
   input  logic turn_en,
   output logic hold_max,
   output logic expired
);

   // One spare bit keeps a MAX_HOLD of 0 (preemption off) legal.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
   localparam logic [2:0] TURN_LOAD = 3'(TURNAROUND_CYCLES - 1);

   logic [HW-1:0] hold_cnt;
   logic [2:0]    turn_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_cnt <= '0;
      end else if (clear) begin
         hold_cnt <= '0;
      end else if (hold_en && hold_cnt != HOLD_LIM) begin
         hold_cnt <= hold_cnt + HW'(1);
      end
   end

   // Loaded with N-1 so the TURN state lasts exactly N cycles.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         turn_cnt <= 3'd0;
      end else if (start) begin
         turn_cnt <= TURN_LOAD;
      end else if (turn_en && turn_cnt != 3'd0) begin
         turn_cnt <= turn_cnt - 3'd1;
      end
   end

   assign hold_max = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
   assign expired  = (turn_cnt == 3'd0);

endmodule

// File: rtl/uio_arbiter.sv
// uio_arbiter: round-robin owner of the 8-bit uio pad bank, A vs B.
// Ports: req/out/oe/gnt per requester, uio_in/out/oe pads, rd_data, busy.
module uio_arbiter
   import uio_arb_pkg::*;
#(
   parameter int TURNAROUND_CYCLES = 1,
   parameter int MAX_HOLD          = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_a,
   input  logic [UIO_W-1:0] a_out,
   input  logic [UIO_W-1:0] a_oe,
   output logic             gnt_a,
   input  logic             req_b,
   input  logic [UIO_W-1:0] b_out,
   input  logic [UIO_W-1:0] b_oe,
   output logic             gnt_b,
   input  logic [UIO_W-1:0] uio_in,
   output logic [UIO_W-1:0] rd_data,
   output logic [UIO_W-1:0] uio_out,
   output logic [UIO_W-1:0] uio_oe,
   output logic             busy
);

   arb_state_t state, state_nx;
   owner_t     last_gnt;

   logic a_wins, b_wins;
   logic grant_a, grant_b;
   logic start_turn;
   logic hold_max, turn_done;

   // Contention goes to whoever was not granted last.
   assign a_wins = req_a && (!req_b || last_gnt != OWN_A);
   assign b_wins = req_b && !a_wins;

   always_comb begin
      state_nx   = state;
      grant_a    = 1'b0;
      grant_b    = 1'b0;
      start_turn = 1'b0;
      unique case (state)
         ST_IDLE: begin
            unique case (1'b1)
               a_wins: begin
                  state_nx = ST_OWN_A;
                  grant_a  = 1'b1;
               end
               b_wins: begin
                  state_nx = ST_OWN_B;
                  grant_b  = 1'b1;
               end
               default: ;
            endcase
         end
         ST_OWN_A: begin
            if (!req_a || (hold_max && req_b)) begin
               state_nx   = ST_TURN;
               start_turn = 1'b1;
            end
         end
         ST_OWN_B: begin
            if (!req_b || (hold_max && req_a)) begin
               state_nx   = ST_TURN;
               start_turn = 1'b1;
            end
         end
         ST_TURN: begin
            if (turn_done) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   uio_arb_hold_timer #(
      .MAX_HOLD          (MAX_HOLD),
      .TURNAROUND_CYCLES (TURNAROUND_CYCLES)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (grant_a | grant_b),
      .hold_en  (gnt_a | gnt_b),
      .start    (start_turn),
      .turn_en  (state == ST_TURN),
      .hold_max (hold_max),
      .expired  (turn_done)
   );

   // Pads are driven from the next state, so the granting edge
   // already carries the new owner's data and enables.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         last_gnt <= OWN_NONE;
         rd_data  <= '0;
         uio_out  <= '0;
         uio_oe   <= '0;
      end else begin
         state   <= state_nx;
         rd_data <= uio_in;
         if (grant_a) last_gnt <= OWN_A;
         else if (grant_b) last_gnt <= OWN_B;
         unique case (state_nx)
            ST_OWN_A: begin
               uio_out <= a_out & a_oe;
               uio_oe  <= a_oe;
            end
            ST_OWN_B: begin
               uio_out <= b_out & b_oe;
               uio_oe  <= b_oe;
            end
            default: begin
               uio_out <= '0;
               uio_oe  <= '0;
            end
         endcase
      end
   end

   assign gnt_a = (state == ST_OWN_A);
   assign gnt_b = (state == ST_OWN_B);
   assign busy  = (state != ST_IDLE);

endmodule

// File: tb/tb_uio_arbiter.sv
// tb_uio_arbiter: directed and randomized checks of uio_arbiter.
// Runs with TURNAROUND_CYCLES=1 and MAX_HOLD=4.
module tb_uio_arbiter;

   localparam int TURN = 1;
   localparam int MAXH = 4;

   logic       clk;
   logic       rst_n;
   logic       req_a, req_b;
   logic [7:0] a_out, a_oe, b_out, b_oe;
   logic       gnt_a, gnt_b;
   logic [7:0] uio_in, rd_data, uio_out, uio_oe;
   logic       busy;

   int n_cmp = 0;
   int n_bad = 0;

   uio_arbiter #(
      .TURNAROUND_CYCLES (TURN),
      .MAX_HOLD          (MAXH)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req_a   (req_a),
      .a_out   (a_out),
      .a_oe    (a_oe),
      .gnt_a   (gnt_a),
      .req_b   (req_b),
      .b_out   (b_out),
      .b_oe    (b_oe),
      .gnt_b   (gnt_b),
      .uio_in  (uio_in),
      .rd_data (rd_data),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .busy    (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Grants exclusive, enables only under a grant, on every cycle.
   always @(negedge clk) begin
      n_cmp++;
      if ((gnt_a && gnt_b) || (uio_oe != 8'h00 && !gnt_a && !gnt_b)) begin
         n_bad++;
         $display("FAIL invariant: gnt_a=%b gnt_b=%b uio_oe=%h",
                  gnt_a, gnt_b, uio_oe);
      end
   end

   task automatic test_reset();
      rst_n = 1'b0; uio_in = 8'h5A;
      req_a = 1'b1; a_oe = 8'hFF; a_out = 8'hFF;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_a: got %b want 0", gnt_a); end
      n_cmp++; if (gnt_b !== 1'b0) begin n_bad++; $display("FAIL rst_gnt_b: got %b want 0", gnt_b); end
      n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL rst_oe: got %h want 00", uio_oe); end
      n_cmp++; if (uio_out !== 8'h00) begin n_bad++; $display("FAIL rst_out: got %h want 00", uio_out); end
      n_cmp++; if (rd_data !== 8'h00) begin n_bad++; $display("FAIL rst_rd: got %h want 00", rd_data); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      req_a = 1'b0;
   endtask

   task automatic test_single();
      rst_n = 1'b1; req_a = 1'b1; a_oe = 8'hF0; a_out = 8'hA5;
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL single_gnt: got %b want 1", gnt_a); end
      n_cmp++; if (uio_oe !== 8'hF0) begin n_bad++; $display("FAIL single_oe: got %h want f0", uio_oe); end
      n_cmp++; if (uio_out !== 8'hA0) begin n_bad++; $display("FAIL single_out: got %h want a0", uio_out); end
      a_oe = 8'h0F; a_out = 8'h5A;
      @(negedge clk);
      n_cmp++; if (uio_oe !== 8'h0F) begin n_bad++; $display("FAIL track_oe: got %h want 0f", uio_oe); end
      n_cmp++; if (uio_out !== 8'h0A) begin n_bad++; $display("FAIL track_out: got %h want 0a", uio_out); end
      req_a = 1'b0;
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b0) begin n_bad++; $display("FAIL release_gnt: got %b want 0", gnt_a); end
      n_cmp++; if (uio_oe !== 8'h00) begin n_bad++; $display("FAIL release_oe: got %h want 00", uio_oe); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL turn_busy: got %b want 1", busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_simultaneous();
      rst_n = 1'b0; req_a = 1'b1; req_b = 1'b1;
      a_oe = 8'hFF; a_out = 8'h11; b_oe = 8'hFF; b_out = 8'h22;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b1 || gnt_b !== 1'b0) begin n_bad++; $display("FAIL simul_first: gnt_a=%b gnt_b=%b want 1/0", gnt_a, gnt_b); end
      n_cmp++; if (uio_out !== 8'h11) begin n_bad++; $display("FAIL simul_out_a: got %h want 11", uio_out); end
      req_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL simul_turn: gnt_b=%b busy=%b want 0/0", gnt_b, busy); end
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b1) begin n_bad++; $display("FAIL simul_b_next: got %b want 1", gnt_b); end
      n_cmp++; if (uio_out !== 8'h22) begin n_bad++; $display("FAIL simul_out_b: got %h want 22", uio_out); end
      req_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      req_a = 1'b1; req_b = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL rr_a: got %b want 1", gnt_a); end
      req_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b1) begin n_bad++; $display("FAIL rr_b: got %b want 1", gnt_b); end
      req_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_preempt();
      req_b = 1'b1; b_oe = 8'hC3; b_out = 8'hFF;
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b1) begin n_bad++; $display("FAIL pre_grant_b: got %b want 1", gnt_b); end
      req_a = 1'b1; a_oe = 8'h3C; a_out = 8'hFF;
      for (int i = 1; i <= MAXH; i++) begin
         @(negedge clk);
         n_cmp++; if (gnt_b !== 1'b1) begin n_bad++; $display("FAIL pre_hold%0d: got %b want 1", i, gnt_b); end
      end
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b0 || uio_oe !== 8'h00) begin n_bad++; $display("FAIL pre_drop: gnt_b=%b oe=%h want 0/00", gnt_b, uio_oe); end
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b0) begin n_bad++; $display("FAIL pre_turn: got %b want 0", gnt_a); end
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b1 || uio_oe !== 8'h3C) begin n_bad++; $display("FAIL pre_a: gnt_a=%b oe=%h want 1/3c", gnt_a, uio_oe); end
      req_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b1) begin n_bad++; $display("FAIL pre_b_back: got %b want 1", gnt_b); end
      req_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_no_contention();
      req_a = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 100; i++) begin
         n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL hold_%0d: got %b want 1", i, gnt_a); end
         @(negedge clk);
      end
      req_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      req_b = 1'b1; b_oe = 8'hFF; b_out = 8'h5A;
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b1 || uio_oe !== 8'hFF) begin n_bad++; $display("FAIL mid_own: gnt_b=%b oe=%h want 1/ff", gnt_b, uio_oe); end
      rst_n = 1'b0; req_a = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt_b !== 1'b0 || gnt_a !== 1'b0) begin n_bad++; $display("FAIL mid_gnt: a=%b b=%b want 0/0", gnt_a, gnt_b); end
      n_cmp++; if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin n_bad++; $display("FAIL mid_pads: oe=%h out=%h want 00/00", uio_oe, uio_out); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (gnt_a !== 1'b1) begin n_bad++; $display("FAIL mid_rr_a: got %b want 1", gnt_a); end
      req_a = 1'b0; req_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_read();
      uio_in = 8'h3C;
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'h3C) begin n_bad++; $display("FAIL rd_idle0: got %h want 3c", rd_data); end
      uio_in = 8'hC3; req_a = 1'b1;
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'hC3) begin n_bad++; $display("FAIL rd_idle1: got %h want c3", rd_data); end
      uio_in = 8'h3C;
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'h3C) begin n_bad++; $display("FAIL rd_own0: got %h want 3c", rd_data); end
      uio_in = 8'hC3; req_a = 1'b0;
      @(negedge clk);
      n_cmp++; if (rd_data !== 8'hC3) begin n_bad++; $display("FAIL rd_turn: got %h want c3", rd_data); end
      @(negedge clk);
   endtask

   // Reference model: owner, turnaround cycles left, cycles held since
   // grant and the last winner, advanced once per clock from the rules.
   task automatic test_random();
      int own, turn, held, last;
      logic mine, other;
      logic [7:0] x_oe, x_out, x_rd;
      own = 0; turn = 0; held = 0; last = 0;
      for (int n = 0; n < 3000; n++) begin
         rst_n = (n == 0) ? 1'b0 : ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 5) == 0) req_a = ~req_a;
         if ($urandom_range(0, 5) == 0) req_b = ~req_b;
         a_out = 8'($urandom); a_oe = 8'($urandom);
         b_out = 8'($urandom); b_oe = 8'($urandom);
         uio_in = 8'($urandom);
         if (!rst_n) begin
            own = 0; turn = 0; held = 0; last = 0;
         end else if (own == 0 && turn == 0) begin
            if (req_a && (!req_b || last != 1)) begin
               own = 1; held = 0; last = 1;
            end else if (req_b) begin
               own = 2; held = 0; last = 2;
            end
         end else if (own != 0) begin
            mine  = (own == 1) ? req_a : req_b;
            other = (own == 1) ? req_b : req_a;
            if (!mine || (MAXH > 0 && held >= MAXH && other)) begin
               own = 0; turn = TURN;
            end else begin
               held++;
            end
         end else begin
            turn--;
         end
         x_oe  = (own == 1) ? a_oe : (own == 2) ? b_oe : 8'h00;
         x_out = (own == 1) ? (a_out & a_oe) :
                 (own == 2) ? (b_out & b_oe) : 8'h00;
         x_rd  = rst_n ? uio_in : 8'h00;
         @(negedge clk);
         n_cmp++; if (gnt_a !== (own == 1)) begin n_bad++; $display("FAIL rnd_gnt_a @%0d: got %b want %b", n, gnt_a, own == 1); end
         n_cmp++; if (gnt_b !== (own == 2)) begin n_bad++; $display("FAIL rnd_gnt_b @%0d: got %b want %b", n, gnt_b, own == 2); end
         n_cmp++; if (uio_oe !== x_oe) begin n_bad++; $display("FAIL rnd_oe @%0d: got %h want %h", n, uio_oe, x_oe); end
         n_cmp++; if (uio_out !== x_out) begin n_bad++; $display("FAIL rnd_out @%0d: got %h want %h", n, uio_out, x_out); end
         n_cmp++; if (rd_data !== x_rd) begin n_bad++; $display("FAIL rnd_rd @%0d: got %h want %h", n, rd_data, x_rd); end
         n_cmp++; if (busy !== (own != 0 || turn != 0)) begin n_bad++; $display("FAIL rnd_busy @%0d: got %b want %b", n, busy, own != 0 || turn != 0); end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      req_a = 1'b0; req_b = 1'b0;
      a_out = 8'h00; a_oe = 8'h00;
      b_out = 8'h00; b_oe = 8'h00;
      uio_in = 8'h00;
      test_reset();
      test_single();
      test_simultaneous();
      test_preempt();
      test_no_contention();
      test_reset_mid();
      test_read();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
